bit_serial_adder: RTL

- Adds two WIDTH-bit operands plus a carry-in one bit per clock, LSB first, using a single `full_adder` instance as its arithmetic core.
- Serialises operands into the full adder, registers the carry between bits, and reassembles the sum.
- Sits directly upstream and downstream of `full_adder`: feeds its a/b/c_in and consumes its s_out/c_out.
- Presents valid/ready handshakes on both sides, so it drops into datapaths that cannot afford a WIDTH-bit ripple chain.

---
 rtl/adder_pkg.sv | 17 +
 rtl/full_adder.sv | 16 +
 rtl/bit_serial_adder.sv | 105 ++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding and defaults
// for the serial arithmetic blocks.
package adder_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit combinational adder,
// the arithmetic core of the serial adder.
module full_adder
  import adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s_out,
  output logic c_out
);

  assign s_out = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first serial add of two
// WIDTH-bit operands through one full adder.
module bit_serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_c;

  full_adder u_fa (
    .a     (a_sr_q[0]),
    .b     (b_sr_q[0]),
    .c_in  (carry_q),
    .s_out (fa_s),
    .c_out (fa_c)
  );

  // State and datapath registers; reset abandons any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state: load on accept, one bit per RUN cycle.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d   = a;
          b_sr_d   = b;
          carry_d  = c_in;
          cnt_d    = '0;
          sum_sr_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
        carry_d  = fa_c;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        cnt_d    = cnt_q + ONE;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_sr_q;
  assign c_out     = carry_q;

endmodule
